// File: rtl/regfile_sb_pkg.sv
// Shared widths and constants for the register file and its scoreboard.
// Pending counters track in-flight writes per architectural register.
package regfile_sb_pkg;

    localparam int NUM_REGS    = 32;
    localparam int PEND_W      = 2;
    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = '0;
    localparam logic [RDATA_WIDTH-1:0] ZERO         = '0;
    localparam logic                   WRITE_ENABLE = 1'b1;
    localparam logic                   READ_ENABLE  = 1'b1;

endpackage

// File: rtl/sb_pend_cnt.sv
// Saturating up/down counter of in-flight writes for one register.
// Clear wins; simultaneous inc and dec leave the count unchanged.
module sb_pend_cnt
    import regfile_sb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              full,
    output logic              nz
);

    logic inc_ok;
    logic dec_ok;

    assign full   = (cnt == {PEND_W{1'b1}});
    assign nz     = (cnt != '0);
    assign inc_ok = inc && !full;
    assign dec_ok = dec && nz;

    // Count register: never wraps in either direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with WB bypass and a write-pending scoreboard.
// Raises hazard_o on RAW against in-flight writes or a full WAW counter.
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
    input  logic                   reg1_re_i,
    input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
    input  logic                   reg2_re_i,
    output logic [RDATA_WIDTH-1:0] reg1_rdata_o,
    output logic [RDATA_WIDTH-1:0] reg2_rdata_o,
    input  logic                   issue_i,
    input  logic                   issue_we_i,
    input  logic [RADDR_WIDTH-1:0] issue_waddr_i,
    input  logic                   wb_we_i,
    input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [RDATA_WIDTH-1:0] wb_wdata_i,
    input  logic                   flush_i,
    output logic                   hazard_o
);

    logic [RDATA_WIDTH-1:0] regs [NUM_REGS];
    logic [PEND_W-1:0]      cnt  [NUM_REGS];
    logic [NUM_REGS-1:0]    full;
    logic [NUM_REGS-1:0]    nz;
    logic [NUM_REGS-1:0]    inc;
    logic [NUM_REGS-1:0]    dec;

    logic wb_ok;
    logic rd1_ok;
    logic rd2_ok;
    logic iss_ok;
    logic accept;
    logic haz1;
    logic haz2;
    logic haz_waw;

    assign wb_ok  = (wb_we_i == WRITE_ENABLE) && (wb_waddr_i != ZERO_REG);
    assign rd1_ok = (reg1_re_i == READ_ENABLE) && (reg1_raddr_i != ZERO_REG);
    assign rd2_ok = (reg2_re_i == READ_ENABLE) && (reg2_raddr_i != ZERO_REG);
    assign iss_ok = issue_we_i && (issue_waddr_i != ZERO_REG);

    // x0 carries no counter.
    assign cnt[0]  = '0;
    assign full[0] = 1'b0;
    assign nz[0]   = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_pend
            sb_pend_cnt u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (inc[g]),
                .dec  (dec[g]),
                .clr  (flush_i),
                .cnt  (cnt[g]),
                .full (full[g]),
                .nz   (nz[g])
            );
        end
    endgenerate

    // Per-register issue/retire strobes from the decoded addresses.
    always_comb begin
        inc = '0;
        dec = '0;
        if (accept) inc[issue_waddr_i] = 1'b1;
        if (wb_ok)  dec[wb_waddr_i]    = 1'b1;
    end

    // A read stalls if writes remain pending after this cycle's retire.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        if (rd1_ok) begin
            haz1 = nz[reg1_raddr_i] &&
                   !(wb_ok && wb_waddr_i == reg1_raddr_i &&
                     cnt[reg1_raddr_i] == PEND_W'(1));
        end
        if (rd2_ok) begin
            haz2 = nz[reg2_raddr_i] &&
                   !(wb_ok && wb_waddr_i == reg2_raddr_i &&
                     cnt[reg2_raddr_i] == PEND_W'(1));
        end
    end

    assign haz_waw  = iss_ok && full[issue_waddr_i];
    assign hazard_o = haz1 || haz2 || haz_waw;
    assign accept   = issue_i && !hazard_o && iss_ok;

    // Read muxes with same-cycle write-back bypass.
    always_comb begin
        reg1_rdata_o = ZERO;
        reg2_rdata_o = ZERO;
        if (rd1_ok) begin
            reg1_rdata_o = (wb_ok && wb_waddr_i == reg1_raddr_i)
                         ? wb_wdata_i : regs[reg1_raddr_i];
        end
        if (rd2_ok) begin
            reg2_rdata_o = (wb_ok && wb_waddr_i == reg2_raddr_i)
                         ? wb_wdata_i : regs[reg2_raddr_i];
        end
    end

    // Architectural state; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= ZERO;
            end
        end else if (wb_ok) begin
            regs[wb_waddr_i] <= wb_wdata_i;
        end
    end

endmodule
